// File: rtl/adc_conv_sched.sv
// adc_conv_sched
//   Round-robin conversion scheduler for the shared differential ADC.
//   Grants one of N_REQ requesters, powers the ADC up, waits one full frame
//   so the analog mux settles, captures the next frame's sign-magnitude result
//   and returns it in two's complement. Powers the ADC down after an idle
//   period, and a watchdog reports a missing SAMPLE strobe as an error.
//
// Ports
//   clk_i, rst_ni    system clock (also the ADC clock), async active-low reset
//   en_i             scheduler enable; low aborts to OFF without a done pulse
//   req_i            level request per channel, held until its done_o pulse
//   done_o, err_o    one-cycle one-hot completion pulse, error flag with it
//   result_raw_o     captured ADC word, sign-magnitude (MSB 1 = positive)
//   result_o         two's complement of result_raw_o
//   busy_o           scheduler is not in OFF
//   adc_pd_o         ADC power-down
//   adc_rst_o        ADC reset (active high)
//   adc_chsel_o      analog mux select = granted channel
//   adc_sample_i     ADC SAMPLE strobe
//   adc_data_i       ADC DATAOUT
module adc_conv_sched #(
  parameter int N_REQ       = 4,
  parameter int NBITS       = 10,
  parameter int PWRUP_CYC   = 8,
  parameter int IDLE_PD_CYC = 64,
  parameter int TMO_CYC     = 40
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [N_REQ-1:0]         req_i,
  output logic [N_REQ-1:0]         done_o,
  output logic                     err_o,
  output logic [NBITS-1:0]         result_raw_o,
  output logic [NBITS-1:0]         result_o,
  output logic                     busy_o,
  output logic                     adc_pd_o,
  output logic                     adc_rst_o,
  output logic [$clog2(N_REQ)-1:0] adc_chsel_o,
  input  logic                     adc_sample_i,
  input  logic [NBITS-1:0]         adc_data_i
);

  localparam int CH_W    = $clog2(N_REQ);
  localparam int MAX_PI  = (PWRUP_CYC > IDLE_PD_CYC) ? PWRUP_CYC : IDLE_PD_CYC;
  localparam int CNT_MAX = (MAX_PI > TMO_CYC) ? MAX_PI : TMO_CYC;
  // The counter only ever holds 0..CNT_MAX-1.
  localparam int CNT_W   = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);

  typedef enum logic [2:0] {
    ST_OFF,
    ST_PWRUP,
    ST_SYNC,
    ST_CONV,
    ST_ARB
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic [CH_W-1:0]    chsel_q, chsel_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic               err_q, err_d;
  logic [NBITS-1:0]   raw_q, raw_d;
  logic               pd_q, pd_d;
  logic               rst_q, rst_d;
  logic               sample_q;

  logic               rise;
  logic               gnt_vld;
  logic [CH_W-1:0]    gnt_idx;
  logic [CH_W-1:0]    cand;

  // Sign-magnitude (MSB 1 = positive) to two's complement. The magnitude
  // has one bit less than the result, so negation cannot overflow.
  function automatic logic [NBITS-1:0] sm_to_twos(input logic [NBITS-1:0] raw);
    logic [NBITS-1:0] mag;
    mag = {1'b0, raw[NBITS-2:0]};
    return raw[NBITS-1] ? mag : (~mag + 1'b1);
  endfunction

  assign rise = adc_sample_i & ~sample_q;

  // Round-robin search starting one past the last granted channel, so a
  // requester that keeps its request up is served again only after the others.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    cand    = ptr_q;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = CH_W'((int'(ptr_q) + k) % N_REQ);
      if (!gnt_vld && req_i[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    chsel_d = chsel_q;
    done_d  = '0;
    err_d   = 1'b0;
    raw_d   = raw_q;

    unique case (state_q)
      ST_OFF: begin
        if (en_i && gnt_vld) begin
          ptr_d   = gnt_idx;
          chsel_d = gnt_idx;
          state_d = ST_PWRUP;
          cnt_d   = '0;
        end
      end
      ST_PWRUP: begin
        if (int'(cnt_q) + 1 >= PWRUP_CYC) begin
          state_d = ST_SYNC;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // The frame in flight at SYNC entry was sampled with the old mux
      // setting; it is skipped and the next full frame is converted.
      ST_SYNC, ST_CONV: begin
        if (rise) begin
          cnt_d = '0;
          if (state_q == ST_SYNC) begin
            state_d = ST_CONV;
          end else begin
            raw_d   = adc_data_i;
            done_d  = N_REQ'(1) << chsel_q;
            state_d = ST_ARB;
          end
        end else if (int'(cnt_q) >= TMO_CYC - 1) begin
          // Missing strobe: report an error result and power-cycle the ADC.
          raw_d   = '0;
          done_d  = N_REQ'(1) << chsel_q;
          err_d   = 1'b1;
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ARB: begin
        if (en_i && gnt_vld) begin
          ptr_d   = gnt_idx;
          chsel_d = gnt_idx;
          state_d = ST_SYNC;
          cnt_d   = '0;
        end else if (int'(cnt_q) + 1 >= IDLE_PD_CYC) begin
          state_d = ST_OFF;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_OFF;
        cnt_d   = '0;
      end
    endcase

    // Disable wins over everything: any pending conversion is dropped silently.
    if (!en_i) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      done_d  = '0;
      err_d   = 1'b0;
      raw_d   = raw_q;
      ptr_d   = ptr_q;
      chsel_d = chsel_q;
    end

    // ADC controls are registered from the next state so they never glitch.
    pd_d  = (state_d == ST_OFF);
    rst_d = (state_d == ST_OFF) || (state_d == ST_PWRUP);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      ptr_q    <= CH_W'(N_REQ - 1);
      chsel_q  <= '0;
      done_q   <= '0;
      err_q    <= 1'b0;
      raw_q    <= '0;
      pd_q     <= 1'b1;
      rst_q    <= 1'b1;
      sample_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      chsel_q  <= chsel_d;
      done_q   <= done_d;
      err_q    <= err_d;
      raw_q    <= raw_d;
      pd_q     <= pd_d;
      rst_q    <= rst_d;
      sample_q <= adc_sample_i;
    end
  end

  assign done_o       = done_q;
  assign err_o        = err_q;
  assign result_raw_o = raw_q;
  assign result_o     = sm_to_twos(raw_q);
  assign busy_o       = (state_q != ST_OFF);
  assign adc_pd_o     = pd_q;
  assign adc_rst_o    = rst_q;
  assign adc_chsel_o  = chsel_q;

endmodule

// File: tb/tb_adc_conv_sched.sv
// Testbench for adc_conv_sched with a behavioural 15-cycle-frame ADC model
// and a scoreboard of expected completions.
module tb_adc_conv_sched;

  localparam int N_REQ = 4;
  localparam int NBITS = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b1;
  logic [N_REQ-1:0] req = '0;
  logic [N_REQ-1:0] done_o;
  logic             err_o;
  logic [NBITS-1:0] result_raw_o;
  logic [NBITS-1:0] result_o;
  logic             busy_o;
  logic             adc_pd_o;
  logic             adc_rst_o;
  logic [1:0]       adc_chsel_o;

  // ADC model: frame counter, SAMPLE strobe, DATAOUT one cycle ahead of it
  logic [3:0]       fcnt = '0;
  logic             smp = 1'b0;
  logic [NBITS-1:0] dat = '0;
  logic             kill = 1'b0;
  logic [NBITS-1:0] ch_raw [N_REQ];

  always #5 clk = ~clk;

  adc_conv_sched dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .req_i        (req),
    .done_o       (done_o),
    .err_o        (err_o),
    .result_raw_o (result_raw_o),
    .result_o     (result_o),
    .busy_o       (busy_o),
    .adc_pd_o     (adc_pd_o),
    .adc_rst_o    (adc_rst_o),
    .adc_chsel_o  (adc_chsel_o),
    .adc_sample_i (smp),
    .adc_data_i   (dat)
  );

  always @(posedge clk) begin
    if (adc_pd_o || adc_rst_o) begin
      fcnt <= '0;
      smp  <= 1'b0;
    end else begin
      fcnt <= (fcnt == 4'd14) ? 4'd0 : fcnt + 4'd1;
      smp  <= (fcnt == 4'd13) && !kill;
      if (fcnt == 4'd12) dat <= ch_raw[adc_chsel_o];
    end
  end

  typedef struct {
    logic [3:0] done;
    logic       err;
    logic [9:0] raw;
    logic [9:0] res;
    logic [1:0] ch;
  } exp_t;

  exp_t sb_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] d, input logic er, input logic [9:0] r,
                      input logic [9:0] s, input logic [1:0] c);
    exp_t x;
    x.done = d; x.err = er; x.raw = r; x.res = s; x.ch = c;
    sb_q.push_back(x);
  endtask

  // Monitor: every done_o pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (done_o !== '0) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done_o=%b, want no completion", done_o);
      end else begin
        e = sb_q.pop_front();
        check("mon_done", 32'(done_o), 32'(e.done));
        check("mon_err", 32'(err_o), 32'(e.err));
        check("mon_raw", 32'(result_raw_o), 32'(e.raw));
        check("mon_result", 32'(result_o), 32'(e.res));
        check("mon_chsel", 32'(adc_chsel_o), 32'(e.ch));
      end
    end
  end

  task automatic wait_done(input string name, input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o == '0 && n < max);
    if (done_o == '0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got no done_o, want one within %0d cycles", name, max);
    end
  endtask

  task automatic wait_sync(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((adc_rst_o || adc_pd_o) && n < 20);
    if (adc_rst_o || adc_pd_o) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: got adc_rst_o=%b, want 0 within 20 cycles", name, adc_rst_o);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_pd"}, 32'(adc_pd_o), 32'd1);
    check({tag, "_rst"}, 32'(adc_rst_o), 32'd1);
    check({tag, "_busy"}, 32'(busy_o), 32'd0);
    check({tag, "_chsel"}, 32'(adc_chsel_o), 32'd0);
    check({tag, "_done"}, 32'(done_o), 32'd0);
    check({tag, "_err"}, 32'(err_o), 32'd0);
    check({tag, "_raw"}, 32'(result_raw_o), 32'd0);
    check({tag, "_result"}, 32'(result_o), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, want completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int n;
    int off_cnt;
    int dcnt;

    ch_raw[0] = 10'h2FF;  // +255
    ch_raw[1] = 10'h1FF;  // -511
    ch_raw[2] = 10'h3FF;  // +511
    ch_raw[3] = 10'h000;  // sign 0, mag 0 -> 0

    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_rst");

    // Round robin with all four requests held: ch0,ch1,ch2,ch3,ch0.
    push(4'b0001, 1'b0, 10'h2FF, 10'h0FF, 2'd0);
    push(4'b0010, 1'b0, 10'h1FF, 10'h201, 2'd1);
    push(4'b0100, 1'b0, 10'h3FF, 10'h1FF, 2'd2);
    push(4'b1000, 1'b0, 10'h000, 10'h000, 2'd3);
    push(4'b0001, 1'b0, 10'h2FF, 10'h0FF, 2'd0);
    req = 4'b1111;
    off_cnt = 0;
    for (int r = 0; r < 5; r++) begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
        if (!busy_o) off_cnt++;
      end while (done_o == '0 && n < 45);
      if (done_o == '0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL rr_done_%0d: got no done_o, want one within 45 cycles", r);
      end
    end
    check("rr_no_off", 32'(off_cnt), 32'd0);
    req = '0;

    // Idle power-down lands exactly IDLE_PD_CYC cycles after the last done.
    repeat (63) @(negedge clk);
    check("idle63_pd", 32'(adc_pd_o), 32'd0);
    check("idle63_busy", 32'(busy_o), 32'd1);
    @(negedge clk);
    check("idle64_pd", 32'(adc_pd_o), 32'd1);
    check("idle64_rst", 32'(adc_rst_o), 32'd1);
    check("idle64_busy", 32'(busy_o), 32'd0);

    // Single positive conversion from OFF, within 40 cycles.
    push(4'b0001, 1'b0, 10'h2FF, 10'h0FF, 2'd0);
    req = 4'b0001;
    wait_done("t1_done", 40, n);
    check("t1_latency_le40", 32'(n <= 40), 32'd1);
    req = '0;

    // Negative on ch2: zero input first, then -255.
    ch_raw[2] = 10'h000;
    push(4'b0100, 1'b0, 10'h000, 10'h000, 2'd2);
    req = 4'b0100;
    wait_done("t2a_done", 40, n);
    req = '0;
    ch_raw[2] = 10'h0FF;
    push(4'b0100, 1'b0, 10'h0FF, 10'h301, 2'd2);
    req = 4'b0100;
    wait_done("t2b_done", 40, n);
    req = '0;

    // Disable from ARB returns to OFF on the next cycle.
    en = 1'b0;
    @(negedge clk);
    check("en_arb_busy", 32'(busy_o), 32'd0);
    check("en_arb_pd", 32'(adc_pd_o), 32'd1);
    en = 1'b1;

    // Disable mid-SYNC: OFF next cycle, no done, results keep their value.
    req = 4'b0010;
    wait_sync("t6b_sync");
    repeat (3) @(negedge clk);
    en  = 1'b0;
    req = '0;
    @(negedge clk);
    check("en_sync_busy", 32'(busy_o), 32'd0);
    check("en_sync_pd", 32'(adc_pd_o), 32'd1);
    check("en_sync_rst", 32'(adc_rst_o), 32'd1);
    dcnt = 0;
    repeat (45) begin
      @(negedge clk);
      if (done_o != '0) dcnt++;
    end
    check("en_sync_no_done", 32'(dcnt), 32'd0);
    check("en_sync_raw_kept", 32'(result_raw_o), 32'h0FF);
    check("en_sync_res_kept", 32'(result_o), 32'h301);
    en = 1'b1;

    // Async reset mid-CONV on ch3.
    req = 4'b1000;
    wait_sync("t6a_sync");
    repeat (20) @(negedge clk);
    check("pre_rst_chsel", 32'(adc_chsel_o), 32'd3);
    rst_n = 1'b0;
    #1;
    check_reset_vals("mid_conv_rst");
    req = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Watchdog: no SAMPLE strobe after grant.
    kill = 1'b1;
    push(4'b0010, 1'b1, 10'h000, 10'h000, 2'd1);
    req = 4'b0010;
    wait_sync("t5_sync");
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done_o == '0 && n < 60);
    req = '0;
    check("t5_tmo_cycles", 32'(n), 32'd40);
    check("t5_busy", 32'(busy_o), 32'd0);
    check("t5_pd", 32'(adc_pd_o), 32'd1);
    kill = 1'b0;

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
